elastic_pipe_stage: RTL and testbench

//  Parametrised, handshaked inter-stage pipeline register (decode->execute and peers).
//  Two-entry skid buffer gives full throughput under valid/ready backpressure.

---
 rtl/elastic_pipe_stage.sv | 144 ++++++++++++++
 tb/tb_elastic_pipe_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_stage.sv
// -----------------------------------------------------------------------------
// elastic_pipe_stage
//   Handshaked inter-stage pipeline register built around a two-entry skid
//   buffer, so a full stage still gives one transfer per cycle under
//   valid/ready backpressure. Supports a multi-source flush, a freeze (hold)
//   input, a NOP bubble payload and saturating stall/bubble counters.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake, in_payload accepted on in_fire
//   in_payload          upstream payload
//   out_valid/out_ready downstream handshake
//   out_payload         head entry, or NOP payload when nothing is held
//   flush               any bit squashes every held entry
//   hold                freeze: no transfers, state held
//   perf_clear          synchronous clear of both counters
//   stall_cycles        cycles with in_valid=1 and in_ready=0 (saturating)
//   bubbles_inserted    cycles with out_ready=1 and out_valid=0 (saturating)
//   occupancy           registered entry count (0, 1 or 2)
// -----------------------------------------------------------------------------
module elastic_pipe_stage #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter logic [31:0] NOP_PAYLOAD   = 32'h0000_0013,
    parameter int unsigned NUM_FLUSH_SRC = 2,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_payload,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_payload,
    input  logic [NUM_FLUSH_SRC-1:0] flush,
    input  logic                     hold,
    input  logic                     perf_clear,
    output logic [CNT_WIDTH-1:0]     stall_cycles,
    output logic [CNT_WIDTH-1:0]     bubbles_inserted,
    output logic [1:0]               occupancy
);

    localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(NOP_PAYLOAD);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  flush_any;
    logic                  in_fire;
    logic                  out_fire;

    assign flush_any = |flush;

    // Handshake: flush/hold/reset block both directions; a flushing cycle
    // still shows the old head on out_payload but never reports it valid.
    assign in_ready  = (state_q != ST_FULL) & ~flush_any & ~hold & ~reset;
    assign out_valid = (state_q != ST_EMPTY) & ~flush_any & ~hold & ~reset;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_payload = main_q;
    assign occupancy   = 2'(state_q);

    // State and payload registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP;
            skid_q  <= NOP;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state and payload steering
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_any) begin
            state_d = ST_EMPTY;
            main_d  = NOP;
            skid_d  = NOP;
        end else if (!hold) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_payload;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_payload;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = in_payload;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = NOP;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain side can move
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Saturating stall counter; clear beats a same-cycle increment
    always_ff @(posedge clock) begin
        if (reset || perf_clear) begin
            stall_cycles <= '0;
        end else if (in_valid && !in_ready && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

    // Saturating bubble counter
    always_ff @(posedge clock) begin
        if (reset || perf_clear) begin
            bubbles_inserted <= '0;
        end else if (out_ready && !out_valid && (bubbles_inserted != CNT_MAX)) begin
            bubbles_inserted <= bubbles_inserted + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipe_stage
//   Self-checking bench: a table of per-cycle vectors with expected handshake
//   outputs, a payload scoreboard, and hand-written sequences for counters
//   and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_elastic_pipe_stage;

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 4;
    localparam int unsigned NV  = 26;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_payload;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_payload;
    logic [1:0]    flush;
    logic          hold;
    logic          perf_clear;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] bubbles_inserted;
    logic [1:0]    occupancy;

    elastic_pipe_stage #(
        .DATA_WIDTH   (DW),
        .NOP_PAYLOAD  (NOP),
        .NUM_FLUSH_SRC(2),
        .CNT_WIDTH    (CW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_payload      (in_payload),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_payload     (out_payload),
        .flush           (flush),
        .hold            (hold),
        .perf_clear      (perf_clear),
        .stall_cycles    (stall_cycles),
        .bubbles_inserted(bubbles_inserted),
        .occupancy       (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic [31:0] ip;
        logic        ordy;
        logic [1:0]  fl;
        logic        hd;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_op;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t        vecs [NV];
    logic [31:0] sb [$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          pops = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic setv(input int i, input logic iv, input logic [31:0] ip, input logic ordy,
                        input logic [1:0] fl, input logic hd, input logic e_ir,
                        input logic e_ov, input logic [31:0] e_op, input logic [1:0] e_occ);
        vecs[i].iv    = iv;
        vecs[i].ip    = ip;
        vecs[i].ordy  = ordy;
        vecs[i].fl    = fl;
        vecs[i].hd    = hd;
        vecs[i].e_ir  = e_ir;
        vecs[i].e_ov  = e_ov;
        vecs[i].e_op  = e_op;
        vecs[i].e_occ = e_occ;
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [31:0] ip,
                         input logic ordy, input logic [1:0] fl, input logic hd, input logic pc);
        reset      = rst;
        in_valid   = iv;
        in_payload = ip;
        out_ready  = ordy;
        flush      = fl;
        hold       = hd;
        perf_clear = pc;
    endtask

    // Apply vectors lo..hi: drive on negedge, check before the next posedge
    task automatic run(input int lo, input int hi);
        vec_t        cur;
        logic [31:0] exp;
        for (int i = lo; i <= hi; i++) begin
            cur = vecs[i];
            @(negedge clock);
            drive(1'b0, cur.iv, cur.ip, cur.ordy, cur.fl, cur.hd, 1'b0);
            #1;
            chk($sformatf("v%0d in_ready", i),    32'(in_ready),  32'(cur.e_ir));
            chk($sformatf("v%0d out_valid", i),   32'(out_valid), 32'(cur.e_ov));
            chk($sformatf("v%0d out_payload", i), out_payload,    cur.e_op);
            chk($sformatf("v%0d occupancy", i),   32'(occupancy), 32'(cur.e_occ));
            if (out_valid && cur.ordy) begin
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d unexpected output", i), out_payload, 32'hFFFF_FFFF);
                end else begin
                    exp = sb.pop_front();
                    pops++;
                    chk($sformatf("v%0d scoreboard", i), out_payload, exp);
                end
            end
            if (cur.iv && cur.e_ir) sb.push_back(cur.ip);
            if (cur.fl != 2'b00) sb.delete();
        end
    endtask

    task automatic chk_counters(input string tag, input int e_stall, input int e_bub);
        @(posedge clock);
        #1;
        chk({tag, " stall_cycles"},     32'(stall_cycles),     32'(e_stall));
        chk({tag, " bubbles_inserted"}, 32'(bubbles_inserted), 32'(e_bub));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: streaming 1..8, one-cycle latency
        setv(0, 1, 32'd1, 1, 2'b00, 0, 1, 0, NOP, 2'd0);
        for (int k = 1; k <= 7; k++)
            setv(k, 1, 32'(k + 1), 1, 2'b00, 0, 1, 1, 32'(k), 2'd1);
        setv(8, 0, 32'd0, 1, 2'b00, 0, 1, 1, 32'd8, 2'd1);
        setv(9, 0, 32'd0, 1, 2'b00, 0, 1, 0, NOP, 2'd0);
        // 2: backpressure, C waits upstream
        setv(10, 1, 32'hA, 0, 2'b00, 0, 1, 0, NOP,    2'd0);
        setv(11, 1, 32'hB, 0, 2'b00, 0, 1, 1, 32'hA,  2'd1);
        setv(12, 1, 32'hC, 0, 2'b00, 0, 0, 1, 32'hA,  2'd2);
        setv(13, 1, 32'hC, 1, 2'b00, 0, 0, 1, 32'hA,  2'd2);
        setv(14, 1, 32'hC, 1, 2'b00, 0, 1, 1, 32'hB,  2'd1);
        setv(15, 0, 32'h0, 1, 2'b00, 0, 1, 1, 32'hC,  2'd1);
        setv(16, 0, 32'h0, 0, 2'b00, 0, 1, 0, NOP,    2'd0);
        // 3: flush while FULL, C presented in flush cycle is refused
        setv(17, 1, 32'hA, 0, 2'b00, 0, 1, 0, NOP,    2'd0);
        setv(18, 1, 32'hB, 0, 2'b00, 0, 1, 1, 32'hA,  2'd1);
        setv(19, 1, 32'hC, 0, 2'b10, 0, 0, 0, 32'hA,  2'd2);
        setv(20, 0, 32'h0, 1, 2'b00, 0, 1, 0, NOP,    2'd0);
        // 4: hold keeps state, hold+flush empties
        setv(21, 1, 32'hD, 0, 2'b00, 0, 1, 0, NOP,    2'd0);
        setv(22, 0, 32'h0, 1, 2'b00, 1, 0, 0, 32'hD,  2'd1);
        setv(23, 1, 32'hE, 1, 2'b00, 1, 0, 0, 32'hD,  2'd1);
        setv(24, 0, 32'h0, 0, 2'b01, 1, 0, 0, 32'hD,  2'd1);
        setv(25, 0, 32'h0, 0, 2'b00, 0, 1, 0, NOP,    2'd0);

        drive(1'b1, 0, 32'h0, 0, 2'b00, 0, 0);
        repeat (2) @(posedge clock);

        run(0, 9);
        chk_counters("stream", 0, 2);
        run(10, 16);
        chk_counters("backpressure", 2, 2);
        run(17, 20);
        chk_counters("flush", 3, 3);
        run(21, 25);
        chk_counters("hold", 4, 5);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        chk("scoreboard pops",    32'(pops),      32'd11);

        // 5: counter clear, saturation, clear beats increment
        @(negedge clock);
        drive(1'b0, 0, 32'h0, 0, 2'b00, 0, 1);
        chk_counters("perf_clear", 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            drive(1'b0, 1, 32'(100 + i), 0, 2'b00, 0, 0);
        end
        @(posedge clock);
        #1;
        chk("sat stall_cycles", 32'(stall_cycles), 32'd15);
        chk("sat occupancy",    32'(occupancy),    32'd2);
        @(negedge clock);
        drive(1'b0, 1, 32'h99, 0, 2'b00, 0, 1);
        chk_counters("clear wins", 0, 0);

        // 6: reset while FULL, then first payload after reset
        @(negedge clock);
        drive(1'b1, 1, 32'h55, 1, 2'b00, 0, 0);
        #1;
        chk("in_ready during reset", 32'(in_ready), 32'd0);
        @(negedge clock);
        drive(1'b0, 0, 32'h0, 0, 2'b00, 0, 0);
        #1;
        chk("rst occupancy",   32'(occupancy),        32'd0);
        chk("rst out_valid",   32'(out_valid),        32'd0);
        chk("rst out_payload", out_payload,           NOP);
        chk("rst stall",       32'(stall_cycles),     32'd0);
        chk("rst bubbles",     32'(bubbles_inserted), 32'd0);
        chk("rst in_ready",    32'(in_ready),         32'd1);
        @(negedge clock);
        drive(1'b0, 1, 32'h55, 1, 2'b00, 0, 0);
        #1;
        chk("post-rst in cycle out_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        drive(1'b0, 0, 32'h0, 1, 2'b00, 0, 0);
        #1;
        chk("post-rst latency out_valid", 32'(out_valid), 32'd1);
        chk("post-rst out_payload",       out_payload,    32'h55);
        @(negedge clock);
        drive(1'b0, 0, 32'h0, 0, 2'b00, 0, 0);
        #1;
        chk("post-rst drained", 32'(out_valid), 32'd0);
        chk("post-rst bubbles", 32'(bubbles_inserted), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
